// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and helpers for the 7-segment scan controller
package fnd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int DEF_CLK_DIV = 50000;
  localparam int MAX_DIGITS = 32;

  // Active-low enables: ones in the low n bits switch every digit off
  function automatic logic [MAX_DIGITS-1:0] sel_all_off(input int n);
    logic [MAX_DIGITS-1:0] m;
    for (int i = 0; i < MAX_DIGITS; i++) m[i] = (i < n);
    return m;
  endfunction

  // Nibbles outside 0..9 are shown as 0
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? '0 : d;
  endfunction

endpackage

// File: rtl/fnd_scan_timer.sv
// rtl/fnd_scan_timer.sv - slot prescaler, slot index and frame strobes
module fnd_scan_timer
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = DEF_CLK_DIV,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PRE_W = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx_next,        // slot index in the next cycle
  output logic             slot_start_next, // next cycle is cycle 0 of a slot
  output logic             frame_boundary   // this cycle is the last of the frame
);

  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] idx;
  logic             presc_last;
  logic             idx_last;

  assign presc_last      = (presc == PRE_W'(CLK_DIV - 1));
  assign idx_last        = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_boundary  = presc_last && idx_last;
  assign slot_start_next = presc_last;
  assign idx_next        = !presc_last ? idx : (idx_last ? '0 : idx + 1'b1);

  // Prescaler wraps every slot; slot index advances on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc_last ? '0 : presc + 1'b1;
      idx   <= idx_next;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - multiplexed 7-segment scan with double-buffered value
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int BLANK_LZ = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [BCD_W*NUM_DIGITS-1:0]   wr_data,
  output logic                          wr_ready,
  output logic [BCD_W-1:0]              number,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = BCD_W * NUM_DIGITS;
  localparam logic [MAX_DIGITS-1:0] SEL_OFF_W = sel_all_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_OFF_W[NUM_DIGITS-1:0];

  logic [IDX_W-1:0]    idx_next;
  logic                slot_start_next;
  logic                frame_boundary;
  logic [DW-1:0]       disp;
  logic [DW-1:0]       pend;
  logic [DW-1:0]       disp_next;
  logic [DW-1:0]       wr_clamped;
  logic                commit;
  logic                zero_run;
  logic [BCD_W-1:0]    digs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blanked;

  fnd_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .CLK_DIV   (CLK_DIV)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .idx_next       (idx_next),
    .slot_start_next(slot_start_next),
    .frame_boundary (frame_boundary)
  );

  // Pending buffer only changes hands on the last cycle of a frame
  assign commit    = frame_boundary && !wr_ready;
  assign disp_next = commit ? pend : disp;

  // Clamp each incoming nibble so only valid BCD reaches the pending buffer
  always_comb begin
    wr_clamped = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      wr_clamped[k*BCD_W +: BCD_W] = bcd_clamp(wr_data[k*BCD_W +: BCD_W]);
  end

  // Split the upcoming display value into digits and mark leading zeros
  always_comb begin
    digs     = '{default: '0};
    blanked  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      digs[k]    = disp_next[k*BCD_W +: BCD_W];
      zero_run   = zero_run && (digs[k] == '0);
      blanked[k] = (BLANK_LZ != 0) && (k != 0) && zero_run;
    end
  end

  // Write handshake: wr_ready low doubles as the pending-valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp     <= '0;
      pend     <= '0;
      wr_ready <= 1'b1;
    end else if (commit) begin
      disp     <= pend;
      wr_ready <= 1'b1;
    end else if (wr_en && wr_ready) begin
      pend     <= wr_clamped;
      wr_ready <= 1'b0;
    end
  end

  // Scan outputs registered for the slot position the timer enters next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number     <= '0;
      digit_sel  <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_boundary;
      if (slot_start_next) begin
        number    <= digs[idx_next];
        digit_sel <= SEL_OFF;
      end else if (blanked[idx_next]) begin
        digit_sel <= SEL_OFF;
      end else begin
        digit_sel <= ~(NUM_DIGITS'(1) << idx_next);
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - directed bench for fnd_scan_ctrl
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ready, frame_done, rdy0, fd0;
  logic [3:0]  number, num0, sel, sel0;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .number(number), .digit_sel(sel), .frame_done(frame_done)
  );

  fnd_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(rdy0),
    .number(num0), .digit_sel(sel0), .frame_done(fd0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_frame_start();
    while (cyc % 16 != 0) tick();
  endtask

  task automatic test_reset();
    logic [3:0] es;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    nvec++; if (number !== 4'h0) begin nerr++; $display("FAIL reset_number got=%h exp=0", number); end
    nvec++; if (sel !== 4'b1111) begin nerr++; $display("FAIL reset_sel got=%b exp=1111", sel); end
    nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    for (int i = 1; i <= 32; i++) begin
      tick();
      es = ((cyc % 4 == 0) || ((cyc / 4) % 4 != 0)) ? 4'b1111 : 4'b1110;
      nvec++; if (number !== 4'h0) begin nerr++; $display("FAIL idle_number cyc=%0d got=%h exp=0", cyc, number); end
      nvec++; if (sel !== es) begin nerr++; $display("FAIL idle_sel cyc=%0d got=%b exp=%b", cyc, sel, es); end
      nvec++; if (frame_done !== (cyc % 16 == 0)) begin nerr++; $display("FAIL idle_frame_done cyc=%0d got=%b", cyc, frame_done); end
      nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL idle_ready cyc=%0d got=%b exp=1", cyc, wr_ready); end
    end
  endtask

  task automatic test_write_commit();
    logic [3:0] en [4];
    logic [3:0] es [4];
    logic [3:0] e;
    en = '{4'h4, 4'h3, 4'h2, 4'h1};
    es = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    repeat (4) tick();
    wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    while (cyc % 16 != 0) begin
      nvec++; if (wr_ready !== 1'b0) begin nerr++; $display("FAIL wc_ready_low cyc=%0d got=%b exp=0", cyc, wr_ready); end
      nvec++; if (number !== 4'h0) begin nerr++; $display("FAIL wc_old_number cyc=%0d got=%h exp=0", cyc, number); end
      tick();
    end
    for (int p = 0; p < 16; p++) begin
      e = (p % 4 == 0) ? 4'b1111 : es[p / 4];
      nvec++; if (number !== en[p / 4]) begin nerr++; $display("FAIL wc_number p=%0d got=%h exp=%h", p, number, en[p / 4]); end
      nvec++; if (sel !== e) begin nerr++; $display("FAIL wc_sel p=%0d got=%b exp=%b", p, sel, e); end
      nvec++; if (frame_done !== (p == 0)) begin nerr++; $display("FAIL wc_frame_done p=%0d got=%b", p, frame_done); end
      nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL wc_ready p=%0d got=%b exp=1", p, wr_ready); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] en [4];
    logic [3:0] es [4];
    logic [3:0] e;
    en = '{4'h5, 4'h6, 4'h7, 4'h8};
    es = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wr_en = 1'b1; wr_data = 16'h8765;
    tick();
    wr_data = 16'h9999;
    nvec++; if (wr_ready !== 1'b0) begin nerr++; $display("FAIL b2b_ready got=%b exp=0", wr_ready); end
    repeat (5) tick();
    wr_en = 1'b0;
    to_frame_start();
    // two frames of 8765; a write lands on the final boundary cycle of the first
    for (int p = 0; p < 32; p++) begin
      e = (p % 4 == 0) ? 4'b1111 : es[(p / 4) % 4];
      nvec++; if (number !== en[(p / 4) % 4]) begin nerr++; $display("FAIL b2b_number p=%0d got=%h exp=%h", p, number, en[(p / 4) % 4]); end
      nvec++; if (sel !== e) begin nerr++; $display("FAIL b2b_sel p=%0d got=%b exp=%b", p, sel, e); end
      nvec++; if (wr_ready !== (p < 16)) begin nerr++; $display("FAIL b2b_ready p=%0d got=%b", p, wr_ready); end
      if (p == 15) begin wr_en = 1'b1; wr_data = 16'h0321; end
      tick();
      wr_en = 1'b0;
    end
    en = '{4'h1, 4'h2, 4'h3, 4'h0};
    es = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    for (int p = 0; p < 16; p++) begin
      e = (p % 4 == 0) ? 4'b1111 : es[p / 4];
      nvec++; if (number !== en[p / 4]) begin nerr++; $display("FAIL bnd_number p=%0d got=%h exp=%h", p, number, en[p / 4]); end
      nvec++; if (sel !== e) begin nerr++; $display("FAIL bnd_sel p=%0d got=%b exp=%b", p, sel, e); end
      nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL bnd_ready p=%0d got=%b exp=1", p, wr_ready); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] es;
    wr_en = 1'b1; wr_data = 16'h4321;
    tick();
    wr_en = 1'b0;
    while (cyc % 16 != 9) tick();
    nvec++; if (number !== 4'h3) begin nerr++; $display("FAIL ar_pre_number got=%h exp=3", number); end
    nvec++; if (sel !== 4'b1011) begin nerr++; $display("FAIL ar_pre_sel got=%b exp=1011", sel); end
    nvec++; if (wr_ready !== 1'b0) begin nerr++; $display("FAIL ar_pre_ready got=%b exp=0", wr_ready); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (number !== 4'h0) begin nerr++; $display("FAIL ar_number got=%h exp=0", number); end
    nvec++; if (sel !== 4'b1111) begin nerr++; $display("FAIL ar_sel got=%b exp=1111", sel); end
    nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL ar_ready got=%b exp=1", wr_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i <= 16; i++) begin
      es = ((cyc % 4 == 0) || ((cyc / 4) % 4 != 0)) ? 4'b1111 : 4'b1110;
      nvec++; if (number !== 4'h0) begin nerr++; $display("FAIL ar_post_number cyc=%0d got=%h exp=0", cyc, number); end
      nvec++; if (sel !== es) begin nerr++; $display("FAIL ar_post_sel cyc=%0d got=%b exp=%b", cyc, sel, es); end
      nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL ar_post_ready cyc=%0d got=%b exp=1", cyc, wr_ready); end
      nvec++; if (frame_done !== (cyc == 16)) begin nerr++; $display("FAIL ar_post_frame_done cyc=%0d got=%b", cyc, frame_done); end
      if (i < 16) tick();
    end
  endtask

  task automatic test_blanking();
    logic [3:0] en [4];
    logic [3:0] es [4];
    logic [3:0] es0 [4];
    logic [3:0] e, e0;
    en  = '{4'h0, 4'h5, 4'h0, 4'h0};
    es  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    es0 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wr_en = 1'b1; wr_data = 16'h0050;
    tick();
    wr_en = 1'b0;
    to_frame_start();
    for (int p = 0; p < 16; p++) begin
      e  = (p % 4 == 0) ? 4'b1111 : es[p / 4];
      e0 = (p % 4 == 0) ? 4'b1111 : es0[p / 4];
      nvec++; if (number !== en[p / 4]) begin nerr++; $display("FAIL lz_number p=%0d got=%h exp=%h", p, number, en[p / 4]); end
      nvec++; if (sel !== e) begin nerr++; $display("FAIL lz_sel p=%0d got=%b exp=%b", p, sel, e); end
      nvec++; if (num0 !== en[p / 4]) begin nerr++; $display("FAIL nolz_number p=%0d got=%h exp=%h", p, num0, en[p / 4]); end
      nvec++; if (sel0 !== e0) begin nerr++; $display("FAIL nolz_sel p=%0d got=%b exp=%b", p, sel0, e0); end
      tick();
    end
  endtask

  task automatic test_clamp();
    logic [3:0] en [4];
    logic [3:0] es [4];
    logic [3:0] e;
    en = '{4'h7, 4'h0, 4'h0, 4'h0};
    es = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    wr_en = 1'b1; wr_data = 16'h00A7;
    tick();
    wr_en = 1'b0;
    to_frame_start();
    for (int p = 0; p < 16; p++) begin
      e = (p % 4 == 0) ? 4'b1111 : es[p / 4];
      nvec++; if (number !== en[p / 4]) begin nerr++; $display("FAIL clamp_number p=%0d got=%h exp=%h", p, number, en[p / 4]); end
      nvec++; if (sel !== e) begin nerr++; $display("FAIL clamp_sel p=%0d got=%b exp=%b", p, sel, e); end
      nvec++; if (num0 !== en[p / 4]) begin nerr++; $display("FAIL clamp_nolz_number p=%0d got=%h exp=%h", p, num0, en[p / 4]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_back_to_back();
    test_async_reset();
    test_blanking();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
